// File: rtl/a2l2_reld_seq_pkg.sv
// a2l2_pkg: shared types and constants for the A2O L2-side load/reload
// sequencer (a2l2_reld_seq) and its load queue (a2l2_ldq).
//   TT_LOAD      - transaction type code of a core load request
//   state_t      - reload sequencer FSM states
//   ldq_entry_t  - one queued load: line+qw address, core tag, inhibited flag
//   beat_t       - quadword / beat index within a 64B line
package a2l2_pkg;

  localparam logic [0:5] TT_LOAD = 6'b001000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_FILL,
    S_PRE,
    S_XFER
  } state_t;

  typedef struct packed {
    logic [22:59] addr;
    logic [0:4]   tag;
    logic         wimg_i;
  } ldq_entry_t;

  typedef logic [0:1] beat_t;

endpackage

// File: rtl/a2l2_ldq.sv
// a2l2_ldq: DEPTH-entry FIFO of pending core loads.
//   clk, reset  - clock, asynchronous active-high reset
//   push        - enqueue push_data (ignored when full unless popping too)
//   push_data   - entry to enqueue
//   pop         - dequeue the head entry (ignored when empty)
//   head        - current oldest entry (valid when !empty)
//   count       - number of occupied entries
//   full, empty - occupancy flags
module a2l2_ldq
  import a2l2_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  ldq_entry_t    push_data,
  input  logic          pop,
  output ldq_entry_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  ldq_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/a2l2_reld_seq.sv
// a2l2_reld_seq: queues core loads from the L2 request port, issues them one
// at a time to a simple memory read port, buffers the returned line and
// replays it on the core reload interface (data_coming preamble, crit_qw,
// ld_pop credit return).
//   clk, reset               - core clock, asynchronous active-high reset
//   ac_an_req*               - core request port (only TT_LOAD is accepted)
//   an_ac_req_ld_pop         - one load credit returned (cycle after grant)
//   an_ac_reld_*             - reload interface towards the core
//   mem_rd_req/addr/qw/len4  - memory read request, held until mem_rd_gnt
//   mem_rd_data_vld/data/err - memory return beats
//   ldq_ovf_err              - sticky: load arrived while the queue was full
module a2l2_reld_seq
  import a2l2_pkg::*;
#(
  parameter int LDQ_DEPTH = 4,
  parameter int PRE_CYC   = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ac_an_req,
  input  logic [22:63]   ac_an_req_ra,
  input  logic [0:5]     ac_an_req_ttype,
  input  logic           ac_an_req_wimg_i,
  input  logic [0:4]     ac_an_req_ld_core_tag,
  output logic           an_ac_req_ld_pop,
  output logic           an_ac_reld_data_coming,
  output logic           an_ac_reld_data_vld,
  output logic [0:4]     an_ac_reld_core_tag,
  output logic [58:59]   an_ac_reld_qw,
  output logic [0:127]   an_ac_reld_data,
  output logic           an_ac_reld_crit_qw,
  output logic           an_ac_reld_ecc_err_ue,
  output logic           mem_rd_req,
  output logic [22:57]   mem_rd_addr,
  output logic [58:59]   mem_rd_qw,
  output logic           mem_rd_len4,
  input  logic           mem_rd_gnt,
  input  logic           mem_rd_data_vld,
  input  logic [0:127]   mem_rd_data,
  input  logic           mem_rd_err,
  output logic           ldq_ovf_err
);

  localparam int CW = $clog2(LDQ_DEPTH + 1);
  localparam int PW = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;

  state_t        state;
  ldq_entry_t    push_data;
  ldq_entry_t    q_head;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          load_req;
  logic          deq;
  logic          push;
  logic          ovf_set;

  logic [0:127]  line_buf [4];
  logic [0:3]    beat_err;
  beat_t         beat;
  beat_t         nxt_beat;
  beat_t         beat_last;
  beat_t         act_qw;
  logic [0:4]    act_tag;
  logic          act_len4;
  logic [PW-1:0] pre_cnt;

  // Low address bits inside the quadword have no meaning for a line fetch.
  logic          unused_ra_lo;
  assign unused_ra_lo = ^ac_an_req_ra[60:63];

  always_comb begin
    load_req         = ac_an_req && (ac_an_req_ttype == TT_LOAD);
    deq              = (state == S_ADDR) && mem_rd_gnt;
    // A full queue still accepts a load in the cycle its head is dequeued.
    push             = load_req && (!q_full || deq);
    ovf_set          = load_req && (q_count == CW'(LDQ_DEPTH)) && !deq;
    push_data        = '0;
    push_data.addr   = ac_an_req_ra[22:59];
    push_data.tag    = ac_an_req_ld_core_tag;
    push_data.wimg_i = ac_an_req_wimg_i;
    nxt_beat         = beat + 1'b1;
    beat_last        = act_len4 ? 2'b11 : 2'b00;
  end

  a2l2_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (deq),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (state == S_FILL && mem_rd_data_vld) line_buf[beat] <= mem_rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= S_IDLE;
      an_ac_req_ld_pop       <= 1'b0;
      an_ac_reld_data_coming <= 1'b0;
      an_ac_reld_data_vld    <= 1'b0;
      an_ac_reld_core_tag    <= '0;
      an_ac_reld_qw          <= '0;
      an_ac_reld_data        <= '0;
      an_ac_reld_crit_qw     <= 1'b0;
      an_ac_reld_ecc_err_ue  <= 1'b0;
      mem_rd_req             <= 1'b0;
      mem_rd_addr            <= '0;
      mem_rd_qw              <= '0;
      mem_rd_len4            <= 1'b0;
      ldq_ovf_err            <= 1'b0;
      beat_err               <= '0;
      beat                   <= '0;
      act_qw                 <= '0;
      act_tag                <= '0;
      act_len4               <= 1'b0;
      pre_cnt                <= '0;
    end else begin
      an_ac_req_ld_pop       <= deq;
      an_ac_reld_data_coming <= 1'b0;
      if (ovf_set) ldq_ovf_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!q_empty) begin
            state       <= S_ADDR;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= q_head.addr[22:57];
            mem_rd_qw   <= q_head.addr[58:59];
            mem_rd_len4 <= ~q_head.wimg_i;
          end
        end

        S_ADDR: begin
          if (mem_rd_gnt) begin
            state    <= S_FILL;
            mem_rd_req <= 1'b0;
            act_qw   <= mem_rd_qw;
            act_tag  <= q_head.tag;
            act_len4 <= mem_rd_len4;
            beat     <= '0;
            beat_err <= '0;
          end
        end

        S_FILL: begin
          if (mem_rd_data_vld) begin
            beat_err[beat] <= beat_err[beat] | mem_rd_err;
            if (beat == beat_last) begin
              state                  <= S_PRE;
              beat                   <= '0;
              an_ac_reld_data_coming <= 1'b1;
              pre_cnt                <= '0;
            end else begin
              beat <= nxt_beat;
            end
          end
        end

        S_PRE: begin
          if (pre_cnt == PW'(PRE_CYC - 1)) begin
            state                 <= S_XFER;
            an_ac_reld_data_vld   <= 1'b1;
            an_ac_reld_core_tag   <= act_tag;
            an_ac_reld_qw         <= act_qw;
            an_ac_reld_data       <= line_buf[0];
            an_ac_reld_crit_qw    <= 1'b1;
            an_ac_reld_ecc_err_ue <= beat_err[0];
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end

        S_XFER: begin
          // beat holds the index currently on the outputs; load the next one.
          if (beat == beat_last) begin
            state                 <= S_IDLE;
            an_ac_reld_data_vld   <= 1'b0;
            an_ac_reld_crit_qw    <= 1'b0;
            an_ac_reld_ecc_err_ue <= 1'b0;
          end else begin
            beat                  <= nxt_beat;
            an_ac_reld_qw         <= act_qw + nxt_beat;
            an_ac_reld_data       <= line_buf[nxt_beat];
            an_ac_reld_crit_qw    <= 1'b0;
            an_ac_reld_ecc_err_ue <= beat_err[nxt_beat];
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
